// File: rtl/drop_scan.sv
// Iterative hard-drop distance engine: tests one candidate drop per clock and
// reports the largest legal shift. Define DROP_SCAN_GHOST_EN to add the ghost output.
module drop_scan #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 20,
    parameter int N_CELLS  = 4,
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BOARD_W*BOARD_H-1:0]    board,
    input  logic [N_CELLS*ROW_BITS-1:0]   cell_row,
    input  logic [N_CELLS*COL_BITS-1:0]   cell_col,
    output logic                          busy,
    output logic                          done,
    output logic [ROW_BITS-1:0]           shift,
    output logic                          invalid
`ifdef DROP_SCAN_GHOST_EN
    ,
    output logic [BOARD_W*BOARD_H-1:0]    ghost
`endif
);

    localparam int CELLS    = BOARD_W * BOARD_H;
    localparam int IDX_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CELLS-1:0]             board_q, board_d;
    logic [N_CELLS*ROW_BITS-1:0]  row_q, row_d;
    logic [N_CELLS*COL_BITS-1:0]  col_q, col_d;
    logic [ROW_BITS-1:0]          cand_q, cand_d;
    logic [ROW_BITS-1:0]          minRow_q, minRow_d;
    logic [ROW_BITS-1:0]          shift_q, shift_d;
    logic                         invalid_q, invalid_d;
    logic                         startBad;
    logic [ROW_BITS-1:0]          startMin;
    logic                         candOk;
`ifdef DROP_SCAN_GHOST_EN
    logic [CELLS-1:0]             ghost_q, ghost_d;
    logic [CELLS-1:0]             ghostNext;
`endif

    function automatic logic [ROW_BITS-1:0] rowOf(input logic [N_CELLS*ROW_BITS-1:0] v, input int i);
        return v[i*ROW_BITS +: ROW_BITS];
    endfunction

    function automatic logic [COL_BITS-1:0] colOf(input logic [N_CELLS*COL_BITS-1:0] v, input int i);
        return v[i*COL_BITS +: COL_BITS];
    endfunction

    function automatic logic [IDX_BITS-1:0] cellIdx(input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] c);
        return IDX_BITS'(r) * IDX_BITS'(BOARD_W) + IDX_BITS'(c);
    endfunction

    // Range and overlap are checked on the live inputs so a bad start is rejected at E0.
    always_comb begin
        startBad = 1'b0;
        startMin = '1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (rowOf(cell_row, i) < startMin) startMin = rowOf(cell_row, i);
            if (rowOf(cell_row, i) >= ROW_BITS'(BOARD_H) || colOf(cell_col, i) >= COL_BITS'(BOARD_W))
                startBad = 1'b1;
            else if (board[cellIdx(rowOf(cell_row, i), colOf(cell_col, i))])
                startBad = 1'b1;
        end
    end

    // The bound test gates the board lookups so no row below zero is ever indexed.
    always_comb begin
        candOk = (cand_q <= minRow_q);
        for (int i = 0; i < N_CELLS; i++) begin
            if (candOk && board_q[cellIdx(rowOf(row_q, i) - cand_q, colOf(col_q, i))])
                candOk = 1'b0;
        end
    end

`ifdef DROP_SCAN_GHOST_EN
    always_comb begin
        ghostNext = '0;
        for (int i = 0; i < N_CELLS; i++)
            ghostNext[cellIdx(rowOf(row_q, i) - (cand_q - ROW_BITS'(1)), colOf(col_q, i))] = 1'b1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        col_d     = col_q;
        cand_d    = cand_q;
        minRow_d  = minRow_q;
        shift_d   = shift_q;
        invalid_d = invalid_q;
`ifdef DROP_SCAN_GHOST_EN
        ghost_d   = ghost_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    board_d = board;
                    row_d   = cell_row;
                    col_d   = cell_col;
                    shift_d = '0;
`ifdef DROP_SCAN_GHOST_EN
                    ghost_d = '0;
`endif
                    if (startBad) begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        invalid_d = 1'b0;
                        cand_d    = ROW_BITS'(1);
                        minRow_d  = startMin;
                        state_d   = CHECK;
                    end
                end
            end
            CHECK: begin
                if (candOk) begin
                    cand_d = cand_q + ROW_BITS'(1);
                end else begin
                    shift_d = cand_q - ROW_BITS'(1);
`ifdef DROP_SCAN_GHOST_EN
                    ghost_d = ghostNext;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            board_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cand_q    <= '0;
            minRow_q  <= '0;
            shift_q   <= '0;
            invalid_q <= 1'b0;
`ifdef DROP_SCAN_GHOST_EN
            ghost_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cand_q    <= cand_d;
            minRow_q  <= minRow_d;
            shift_q   <= shift_d;
            invalid_q <= invalid_d;
`ifdef DROP_SCAN_GHOST_EN
            ghost_q   <= ghost_d;
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign shift   = shift_q;
    assign invalid = invalid_q;
`ifdef DROP_SCAN_GHOST_EN
    assign ghost   = ghost_q;
`endif

endmodule

// File: tb/tb_drop_scan.sv
// Directed bench for drop_scan: a 10x20 instance and a 12x24 instance,
// with ghost checks when DROP_SCAN_GHOST_EN is defined.
module tb_drop_scan;

    logic         clk = 1'b0;
    logic         rst;
    logic         startA, startB;
    logic [199:0] boardA;
    logic [287:0] boardB;
    logic [19:0]  rowA, colA, rowB, colB;
    logic         busyA, doneA, invalidA, busyB, doneB, invalidB;
    logic [4:0]   shiftA, shiftB;
`ifdef DROP_SCAN_GHOST_EN
    logic [199:0] ghostA;
    logic [287:0] ghostB;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    drop_scan dutA (
        .clk(clk), .rst(rst), .start(startA), .board(boardA),
        .cell_row(rowA), .cell_col(colA),
        .busy(busyA), .done(doneA), .shift(shiftA), .invalid(invalidA)
`ifdef DROP_SCAN_GHOST_EN
        , .ghost(ghostA)
`endif
    );

    drop_scan #(.BOARD_W(12), .BOARD_H(24), .N_CELLS(4), .ROW_BITS(5), .COL_BITS(5)) dutB (
        .clk(clk), .rst(rst), .start(startB), .board(boardB),
        .cell_row(rowB), .cell_col(colB),
        .busy(busyB), .done(doneB), .shift(shiftB), .invalid(invalidB)
`ifdef DROP_SCAN_GHOST_EN
        , .ghost(ghostB)
`endif
    );

    function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1; pulses start across exactly one edge (E0).
    task automatic applyStimulus(input bit useB);
        if (useB) startB = 1'b1; else startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; disturb re-pulses start and floods the board mid-scan.
    task automatic runScan(input bit useB, input bit disturb, output int n, output bit busyOk);
        n = 0;
        busyOk = 1'b1;
        while (!(useB ? doneB : doneA) && n < 60) begin
            if (!(useB ? busyB : busyA)) busyOk = 1'b0;
            if (disturb && n == 3) begin startA = 1'b1; boardA = '1; end
            if (disturb && n == 4) startA = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!(useB ? busyB : busyA)) busyOk = 1'b0;
    endtask

    task automatic scanA(input string tag, input bit disturb, input int expN,
                         input int expShift, input bit expInvalid, input logic [199:0] expGhost);
        int  n;
        bit  busyOk;
        applyStimulus(1'b0);
        runScan(1'b0, disturb, n, busyOk);
        checkOutput({tag, "_latency"}, 320'(n), 320'(expN));
        checkOutput({tag, "_busy"}, 320'(busyOk), 320'(1));
        checkOutput({tag, "_shift"}, 320'(shiftA), 320'(expShift));
        checkOutput({tag, "_invalid"}, 320'(invalidA), 320'(expInvalid));
`ifdef DROP_SCAN_GHOST_EN
        checkOutput({tag, "_ghost"}, 320'(ghostA), 320'(expGhost));
`else
        if (expGhost != expGhost) $display("[TB] unreachable");
`endif
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 320'(doneA), 320'(0));
        checkOutput({tag, "_idle"}, 320'(busyA), 320'(0));
    endtask

    initial begin
        logic [199:0] g;
        logic [287:0] gB;
        int  n;
        bit  busyOk;
        bit  doneSeen;

        rst = 1'b1; startA = 1'b0; startB = 1'b0;
        boardA = '0; boardB = '0;
        rowA = '0; colA = '0; rowB = '0; colB = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 320'(busyA), 320'(0));
        checkOutput("reset_done", 320'(doneA), 320'(0));
        checkOutput("reset_shift", 320'(shiftA), 320'(0));
        checkOutput("reset_invalid", 320'(invalidA), 320'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] O brick on empty board");
        rowA = pack4(18, 18, 19, 19);
        colA = pack4(4, 5, 4, 5);
        g = '0; g[4] = 1'b1; g[5] = 1'b1; g[14] = 1'b1; g[15] = 1'b1;
        scanA("o_empty", 1'b0, 19, 18, 1'b0, g);

        $display("[TB] vertical I onto (5,4)");
        boardA = '0; boardA[54] = 1'b1;
        rowA = pack4(16, 17, 18, 19);
        colA = pack4(4, 4, 4, 4);
        g = '0; g[64] = 1'b1; g[74] = 1'b1; g[84] = 1'b1; g[94] = 1'b1;
        scanA("i_blocked", 1'b0, 11, 10, 1'b0, g);

        $display("[TB] overlapping start");
        boardA = '0; boardA[104] = 1'b1;
        rowA = pack4(10, 10, 11, 11);
        colA = pack4(4, 5, 4, 5);
        scanA("overlap", 1'b0, 0, 0, 1'b1, '0);

        $display("[TB] column out of range");
        boardA = '0;
        rowA = pack4(5, 5, 6, 6);
        colA = pack4(10, 9, 10, 9);
        scanA("col_range", 1'b0, 0, 0, 1'b1, '0);

        $display("[TB] brick resting on row 0");
        rowA = pack4(0, 0, 1, 1);
        colA = pack4(0, 1, 0, 1);
        g = '0; g[0] = 1'b1; g[1] = 1'b1; g[10] = 1'b1; g[11] = 1'b1;
        scanA("floor", 1'b0, 1, 0, 1'b0, g);

        $display("[TB] start and board change during scan");
        boardA = '0;
        rowA = pack4(18, 18, 19, 19);
        colA = pack4(4, 5, 4, 5);
        g = '0; g[4] = 1'b1; g[5] = 1'b1; g[14] = 1'b1; g[15] = 1'b1;
        scanA("disturb", 1'b1, 19, 18, 1'b0, g);

        $display("[TB] reset mid-scan");
        boardA = '0;
        rowA = pack4(8, 8, 9, 9);
        colA = pack4(2, 3, 2, 3);
        applyStimulus(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_busy", 320'(busyA), 320'(0));
        checkOutput("midreset_done", 320'(doneA), 320'(0));
        checkOutput("midreset_shift", 320'(shiftA), 320'(0));
        rst = 1'b0;
        doneSeen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (doneA) doneSeen = 1'b1;
        end
        checkOutput("midreset_no_done", 320'(doneSeen), 320'(0));

        $display("[TB] T brick on 12x24 board");
        boardB = '0;
        rowB = pack4(23, 23, 23, 22);
        colB = pack4(4, 5, 6, 5);
        applyStimulus(1'b1);
        runScan(1'b1, 1'b0, n, busyOk);
        checkOutput("t_wide_latency", 320'(n), 320'(23));
        checkOutput("t_wide_busy", 320'(busyOk), 320'(1));
        checkOutput("t_wide_shift", 320'(shiftB), 320'(22));
        checkOutput("t_wide_invalid", 320'(invalidB), 320'(0));
        gB = '0; gB[16] = 1'b1; gB[17] = 1'b1; gB[18] = 1'b1; gB[5] = 1'b1;
`ifdef DROP_SCAN_GHOST_EN
        checkOutput("t_wide_ghost", 320'(ghostB), 320'(gB));
`else
        if (gB != gB) $display("[TB] unreachable");
`endif
        @(posedge clk); #1;
        checkOutput("t_wide_idle", 320'(busyB), 320'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
